// File: rtl/wb_arbiter_decoder.sv
// Two-master, three-slave Wishbone interconnect.
// A round-robin arbiter grants one master at a time (no preemption), the
// granted address is decoded onto one of three slave windows, unmapped
// strobes produce a one-cycle error, and a stalled slave is cut off by a
// timeout that reports an error to the waiting master.
module wb_arbiter_decoder #(
  parameter logic [31:0] BASE0   = 32'h1000_0000,
  parameter logic [31:0] SIZE0   = 32'h0020_0000,
  parameter logic [31:0] BASE1   = 32'h2000_0000,
  parameter logic [31:0] SIZE1   = 32'h0000_4000,
  parameter logic [31:0] BASE2   = 32'h3000_0000,
  parameter logic [31:0] SIZE2   = 32'h0000_1000,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // master side
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [63:0] m_adr_i,
  input  logic [7:0]  m_sel_i,
  input  logic [63:0] m_dat_i,
  output logic [31:0] m_dat_o,
  output logic [1:0]  m_ack_o,
  output logic [1:0]  m_err_o,
  // slave side
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [2:0]  s_stb_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [95:0] s_dat_i,
  input  logic [2:0]  s_ack_i,
  input  logic [2:0]  s_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  // Window bounds widened to 33 bits so BASE+SIZE can reach 2**32 without wrapping.
  localparam logic [2:0][32:0] WIN_LO = {{1'b0, BASE2}, {1'b0, BASE1}, {1'b0, BASE0}};
  localparam logic [2:0][32:0] WIN_HI = {({1'b0, BASE2} + {1'b0, SIZE2}),
                                         ({1'b0, BASE1} + {1'b0, SIZE1}),
                                         ({1'b0, BASE0} + {1'b0, SIZE0})};

  state_t      r_state;
  state_t      w_state_next;
  logic        r_grant;
  logic        w_grant_next;
  logic        r_last;
  logic        w_last_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;

  logic        w_gcyc;
  logic        w_gstb;
  logic        w_gwe;
  logic [31:0] w_gadr;
  logic [3:0]  w_gsel;
  logic [31:0] w_gdat;
  logic        w_active;
  logic        w_own;
  logic        w_stb;
  logic [2:0]  w_hit;
  logic        w_any_hit;
  logic        w_sack;
  logic        w_serr;
  logic        w_tmo;
  logic        w_ack;
  logic        w_err;
  logic        w_pick;
  logic [2:0][31:0] w_rd_terms;
  logic [31:0] w_rdata;

  // Granted master's bus signals.
  assign w_gcyc = m_cyc_i[r_grant];
  assign w_gstb = m_stb_i[r_grant];
  assign w_gwe  = m_we_i[r_grant];
  assign w_gadr = r_grant ? m_adr_i[63:32] : m_adr_i[31:0];
  assign w_gsel = r_grant ? m_sel_i[7:4]   : m_sel_i[3:0];
  assign w_gdat = r_grant ? m_dat_i[63:32] : m_dat_i[31:0];

  // A grant is live only while the owner keeps its cycle up; dropping cyc
  // releases every output in the same cycle.
  assign w_active = (r_state != ST_IDLE) && w_gcyc;
  assign w_own    = (r_state == ST_OWNED) && w_gcyc;
  assign w_stb    = w_own && w_gstb;

  // Address decode and read-data selection, one slice per slave window.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slave
      assign w_hit[gi] = ({1'b0, w_gadr} >= WIN_LO[gi]) && ({1'b0, w_gadr} < WIN_HI[gi]);
      assign w_rd_terms[gi] = w_hit[gi] ? s_dat_i[32*gi +: 32] : 32'h0;
    end
  endgenerate

  assign w_any_hit = |w_hit;
  assign w_rdata   = w_rd_terms[0] | w_rd_terms[1] | w_rd_terms[2];

  // Only the decoded slave's handshake is honoured.
  assign w_sack = |(s_ack_i & w_hit);
  assign w_serr = |(s_err_i & w_hit);

  // Stall limit reached: error out and withdraw the strobe this cycle.
  assign w_tmo = w_stb && w_any_hit && (r_cnt == TMO_LIMIT);

  // Error takes precedence over a simultaneous acknowledge.
  assign w_ack = w_own && w_sack && !w_serr && !w_tmo;
  assign w_err = (w_own && w_serr) || w_tmo || ((r_state == ST_FAULT) && w_gcyc);

  assign s_cyc_o = w_active;
  assign s_we_o  = w_active && w_gwe;
  assign s_adr_o = w_active ? w_gadr : 32'h0;
  assign s_sel_o = w_active ? w_gsel : 4'h0;
  assign s_dat_o = w_active ? w_gdat : 32'h0;
  assign s_stb_o = (w_stb && !w_tmo) ? w_hit : 3'b000;

  assign m_dat_o = w_active ? w_rdata : 32'h0;
  assign m_ack_o = w_ack ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign m_err_o = w_err ? (r_grant ? 2'b10 : 2'b01) : 2'b00;

  // Round-robin pick: a lone requester wins, a tie goes to the master not served last.
  assign w_pick = (&m_cyc_i) ? ~r_last : m_cyc_i[1];

  // Next-state logic for the arbitration / fault FSM.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_last_next  = r_last;
    unique case (r_state)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          w_state_next = ST_OWNED;
          w_grant_next = w_pick;
          w_last_next  = w_pick;
        end
      end
      ST_OWNED: begin
        if (!w_gcyc) begin
          w_state_next = ST_IDLE;
        end else if (w_gstb && !w_any_hit) begin
          w_state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        w_state_next = w_gcyc ? ST_OWNED : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Stall counter: runs only while a decoded strobe waits without a response.
  always_comb begin
    w_cnt_next = 8'h0;
    if (w_stb && w_any_hit && !w_sack && !w_serr && !w_tmo) begin
      w_cnt_next = r_cnt + 8'h1;
    end
  end

  // State registers; reset leaves master 0 first in line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 8'h0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_decoder.sv
// Self-checking bench for wb_arbiter_decoder: expected responses are queued
// when a transfer is launched and popped when the interconnect answers.
module tb_wb_arbiter_decoder;

  logic        clk_i;
  logic        rst_ni;
  logic [1:0]  m_cyc_i;
  logic [1:0]  m_stb_i;
  logic [1:0]  m_we_i;
  logic [63:0] m_adr_i;
  logic [7:0]  m_sel_i;
  logic [63:0] m_dat_i;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o;
  logic [1:0]  m_err_o;
  logic        s_cyc_o;
  logic        s_we_o;
  logic [2:0]  s_stb_o;
  logic [31:0] s_adr_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_o;
  logic [95:0] s_dat_i;
  logic [2:0]  s_ack_i;
  logic [2:0]  s_err_i;

  typedef struct packed {
    logic [2:0]  stb;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  wb_arbiter_decoder dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_sel_i (m_sel_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_we_o  (s_we_o),
    .s_stb_o (s_stb_o),
    .s_adr_o (s_adr_o),
    .s_sel_o (s_sel_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    m_we_i  = 2'b00;
    m_adr_i = {32'hFFFF_FFF0, 32'hFFFF_FFF0};
    m_sel_i = 8'h00;
    m_dat_i = 64'h0;
    s_ack_i = 3'b000;
    s_err_i = 3'b000;
    s_dat_i = {32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Launch one transfer from master m; k is the slave expected to decode (-1 = none).
  task automatic xfer(input int m, input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                      input int k, input int lat, input bit ack, input bit err,
                      input logic [31:0] rdat, input string tag);
    exp_t e;
    exp_t got;
    logic [2:0] onehot;
    logic [1:0] mbit;
    bit found;
    onehot = (k >= 0) ? 3'(1 << k) : 3'b000;
    mbit   = 2'(1 << m);
    e.stb = onehot;
    e.dat = (k >= 0) ? rdat : 32'h0;
    if (k < 0 || err) begin
      e.ack = 2'b00;
      e.err = mbit;
    end else begin
      e.ack = mbit;
      e.err = 2'b00;
    end
    exp_q.push_back(e);

    @(posedge clk_i);
    #1;
    m_cyc_i = mbit;
    m_stb_i = mbit;
    m_we_i  = we ? mbit : 2'b00;
    m_sel_i = m ? 8'b1011_0000 : 8'b0000_1011;
    if (m == 1) begin
      m_adr_i = {adr, 32'hFFFF_FFF0};
      m_dat_i = {wdat, 32'h5555_AAAA};
    end else begin
      m_adr_i = {32'hFFFF_FFF0, adr};
      m_dat_i = {32'h5555_AAAA, wdat};
    end
    if (k >= 0) s_dat_i[32*k +: 32] = rdat;

    found = 0;
    if (k >= 0) begin
      for (int i = 0; i < 8 && !found; i++) begin
        @(negedge clk_i);
        if (s_stb_o !== 3'b000) found = 1;
      end
      total++;
      if (!found) begin
        bad++;
        $display("FAIL %s strobe_wait: no s_stb_o within 8 cycles, required %b", tag, onehot);
      end
      total++;
      if ({s_adr_o, s_we_o, s_sel_o, s_dat_o} !== {adr, we, 4'b1011, wdat}) begin
        bad++;
        $display("FAIL %s slave_bus: got adr=%h we=%b sel=%b dat=%h, required adr=%h we=%b sel=1011 dat=%h",
                 tag, s_adr_o, s_we_o, s_sel_o, s_dat_o, adr, we, wdat);
      end
      for (int i = 0; i < lat; i++) begin
        @(posedge clk_i);
        #1 s_ack_i = ~onehot;
        @(negedge clk_i);
        total++;
        if (m_ack_o !== 2'b00) begin
          bad++;
          $display("FAIL %s foreign_ack: got m_ack_o=%b, required 00", tag, m_ack_o);
        end
      end
      @(posedge clk_i);
      #1;
      s_ack_i = ack ? onehot : 3'b000;
      s_err_i = err ? onehot : 3'b000;
      @(negedge clk_i);
      found = 1;
    end else begin
      for (int i = 0; i < 8 && !found; i++) begin
        @(negedge clk_i);
        if (m_err_o !== 2'b00) found = 1;
      end
    end

    got = '{stb: s_stb_o, ack: m_ack_o, err: m_err_o, dat: m_dat_o};
    e = exp_q.pop_front();
    total++;
    if (!found || got !== e) begin
      bad++;
      $display("FAIL %s response: got stb=%b ack=%b err=%b dat=%h, required stb=%b ack=%b err=%b dat=%h",
               tag, got.stb, got.ack, got.err, got.dat, e.stb, e.ack, e.err, e.dat);
    end else begin
      $display("xfer %s m%0d adr=%h stb=%b ack=%b err=%b dat=%h ok", tag, m, adr, got.stb, got.ack, got.err, got.dat);
    end

    @(posedge clk_i);
    #1;
    idle_inputs();
    @(negedge clk_i);
    total++;
    if ({s_cyc_o, m_ack_o, m_err_o} !== 5'b0) begin
      bad++;
      $display("FAIL %s release: got cyc=%b ack=%b err=%b, required all 0", tag, s_cyc_o, m_ack_o, m_err_o);
    end
    @(posedge clk_i);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    m_we_i  = 2'b11;
    m_adr_i = {32'h2000_0000, 32'h2000_0000};
    m_sel_i = 8'hFF;
    m_dat_i = 64'hFFFF_FFFF_FFFF_FFFF;
    s_ack_i = 3'b111;
    s_err_i = 3'b111;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if ({s_cyc_o, s_we_o, s_stb_o, m_ack_o, m_err_o} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got cyc=%b we=%b stb=%b ack=%b err=%b, required all 0",
               s_cyc_o, s_we_o, s_stb_o, m_ack_o, m_err_o);
    end
    total++;
    if ({m_dat_o, s_adr_o, s_sel_o, s_dat_o} !== 100'b0) begin
      bad++;
      $display("FAIL reset_data: got mdat=%h adr=%h sel=%h sdat=%h, required all 0",
               m_dat_o, s_adr_o, s_sel_o, s_dat_o);
    end
    idle_inputs();
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if (s_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got s_cyc_o=%b, required 0", s_cyc_o);
    end
    $display("reset checked");
  endtask

  // Both masters request together; expected grant order is pushed up front.
  task automatic test_round_robin();
    exp_t e;
    bit found;
    logic [31:0] a0;
    logic [31:0] a1;
    a0 = 32'h2000_0100;
    a1 = 32'h1000_0200;
    apply_reset();
    e = '0;
    e.dat = a0; exp_q.push_back(e);
    e.dat = a1; exp_q.push_back(e);
    e.dat = a0; exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    m_adr_i = {a1, a0};
    m_cyc_i = 2'b11;
    @(negedge clk_i);
    total++;
    if (s_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL rr_latency: got s_cyc_o=%b before grant edge, required 0", s_cyc_o);
    end
    for (int round = 0; round < 3; round++) begin
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
        if (s_cyc_o === 1'b1) found = 1;
        else @(negedge clk_i);
      end
      e = exp_q.pop_front();
      total++;
      if (!found || s_adr_o !== e.dat) begin
        bad++;
        $display("FAIL rr_grant%0d: got cyc=%b adr=%h, required cyc=1 adr=%h", round, s_cyc_o, s_adr_o, e.dat);
      end else begin
        $display("grant round %0d adr=%h ok", round, s_adr_o);
      end
      @(posedge clk_i);
      #1;
      if (round == 0) m_cyc_i = 2'b10;
      else m_cyc_i = 2'b00;
      @(negedge clk_i);
      total++;
      if (s_cyc_o !== 1'b0) begin
        bad++;
        $display("FAIL rr_release%0d: got s_cyc_o=%b after owner drop, required 0", round, s_cyc_o);
      end
      if (round == 1) begin
        @(posedge clk_i);
        #1 m_cyc_i = 2'b11;
        @(negedge clk_i);
      end
    end
    idle_inputs();
    repeat (2) @(posedge clk_i);
  endtask

  task automatic test_timeout();
    exp_t e;
    exp_t got;
    bit found;
    bit stb_ok;
    int at;
    e = '{stb: 3'b000, ack: 2'b00, err: 2'b01, dat: 32'h3333_3333};
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    s_dat_i[95:64] = 32'h3333_3333;
    m_adr_i = {32'hFFFF_FFF0, 32'h3000_0000};
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    @(negedge clk_i);
    found = 0;
    stb_ok = 1;
    at = 0;
    for (int i = 1; i <= 24 && !found; i++) begin
      @(negedge clk_i);
      if (m_err_o !== 2'b00) begin
        found = 1;
        at = i;
        got = '{stb: s_stb_o, ack: m_ack_o, err: m_err_o, dat: m_dat_o};
      end else if (s_stb_o !== 3'b100) begin
        stb_ok = 0;
      end
    end
    e = exp_q.pop_front();
    total++;
    if (!found || got !== e || at != 17) begin
      bad++;
      $display("FAIL timeout: got cycle=%0d stb=%b ack=%b err=%b dat=%h, required cycle=17 stb=%b ack=%b err=%b dat=%h",
               at, got.stb, got.ack, got.err, got.dat, e.stb, e.ack, e.err, e.dat);
    end else begin
      $display("timeout at cycle %0d err=%b ok", at, got.err);
    end
    total++;
    if (!stb_ok) begin
      bad++;
      $display("FAIL timeout_stb: s_stb_o left 100 before the timeout, required 100 on cycles 1..16");
    end
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    total++;
    if (m_err_o !== 2'b00 || s_stb_o !== 3'b100) begin
      bad++;
      $display("FAIL timeout_after: got err=%b stb=%b, required err=00 stb=100", m_err_o, s_stb_o);
    end
    idle_inputs();
    repeat (2) @(posedge clk_i);
  endtask

  task automatic test_abort_cyc();
    @(posedge clk_i);
    #1;
    m_adr_i = {32'h2000_0100, 32'hFFFF_FFF0};
    m_cyc_i = 2'b10;
    m_stb_i = 2'b10;
    repeat (2) @(negedge clk_i);
    total++;
    if (s_stb_o !== 3'b010) begin
      bad++;
      $display("FAIL abort_pre: got stb=%b, required 010", s_stb_o);
    end
    #2;
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    s_ack_i = 3'b010;
    #1;
    total++;
    if ({s_cyc_o, s_stb_o, m_ack_o} !== 6'b0) begin
      bad++;
      $display("FAIL abort_release: got cyc=%b stb=%b ack=%b, required all 0", s_cyc_o, s_stb_o, m_ack_o);
    end
    @(negedge clk_i);
    total++;
    if (m_ack_o !== 2'b00) begin
      bad++;
      $display("FAIL abort_late_ack: got m_ack_o=%b, required 00", m_ack_o);
    end
    $display("abort checked");
    idle_inputs();
    repeat (2) @(posedge clk_i);
  endtask

  task automatic test_reset_mid();
    @(posedge clk_i);
    #1;
    m_adr_i = {32'hFFFF_FFF0, 32'h2000_0020};
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if ({s_cyc_o, s_we_o, s_stb_o, m_ack_o, m_err_o, m_dat_o, s_adr_o, s_sel_o, s_dat_o} !== 109'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: got cyc=%b stb=%b ack=%b err=%b mdat=%h adr=%h, required all 0",
               s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_dat_o, s_adr_o);
    end
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    s_ack_i = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      total++;
      if ({m_ack_o, m_err_o} !== 4'b0) begin
        bad++;
        $display("FAIL rstmid_late_ack%0d: got ack=%b err=%b, required 00 00", i, m_ack_o, m_err_o);
      end
    end
    $display("mid-transfer reset checked");
    idle_inputs();
    repeat (2) @(posedge clk_i);
  endtask

  task automatic test_back_to_back();
    xfer(0, 1'b1, 32'h1000_0000, 32'h0123_4567, 0, 0, 1'b1, 1'b0, 32'h1111_0000, "b2b_s0_lo");
    xfer(1, 1'b0, 32'h2000_3FFC, 32'h0,         1, 1, 1'b1, 1'b0, 32'h2222_3FFC, "b2b_s1_top");
    xfer(0, 1'b0, 32'h2000_4000, 32'h0,        -1, 0, 1'b0, 1'b0, 32'h0,         "b2b_s1_past");
    xfer(1, 1'b1, 32'h3000_0FFF, 32'h89AB_CDEF, 2, 3, 1'b1, 1'b0, 32'h4444_0FFF, "b2b_s2_top");
    xfer(0, 1'b0, 32'h101F_FFFC, 32'h0,         0, 2, 1'b1, 1'b0, 32'h5555_FFFC, "b2b_s0_top");
    xfer(1, 1'b0, 32'hFFFF_FFFC, 32'h0,        -1, 0, 1'b0, 1'b0, 32'h0,         "b2b_top_addr");
    xfer(0, 1'b0, 32'h0FFF_FFFC, 32'h0,        -1, 0, 1'b0, 1'b0, 32'h0,         "b2b_s0_below");
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    test_reset();
    xfer(0, 1'b0, 32'h2000_0010, 32'h0, 1, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, "read_mem");
    test_round_robin();
    xfer(1, 1'b1, 32'h4000_0000, 32'hCAFE_F00D, -1, 0, 1'b0, 1'b0, 32'h0, "write_unmapped");
    test_timeout();
    xfer(0, 1'b0, 32'h1000_0040, 32'h0, 0, 1, 1'b1, 1'b1, 32'h7777_0040, "ack_err_both");
    test_abort_cyc();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_decoder.md
WB_ARBITER_DECODER -- requirements
Module: wb_arbiter_decoder

Interface
REQ-001 Parameter BASE0, default 'h1000_0000, base address of slave 0 (flash).
REQ-002 Parameter SIZE0, default 'h20_0000, byte size of slave 0.
REQ-003 Parameter BASE1, default 'h2000_0000, base address of slave 1 (memory).
REQ-004 Parameter SIZE1, default 'h4000, byte size of slave 1.
REQ-005 Parameter BASE2, default 'h3000_0000, base address of slave 2 (control).
REQ-006 Parameter SIZE2, default 'h1000, byte size of slave 2.
REQ-007 Parameter TIMEOUT, default 16, cycles an unanswered strobe waits before forced error; range 2..255.
REQ-008 clk_i  in  1  single clock; all state changes on rising edge.
REQ-009 rst_ni  in  1  asynchronous, active-low reset.
REQ-010 m_cyc_i  in  2  per-master cycle request, bit n = master n.
REQ-011 m_stb_i  in  2  per-master strobe.
REQ-012 m_we_i  in  2  per-master write enable.
REQ-013 m_adr_i  in  64  master n address in bits [32n+31:32n].
REQ-014 m_sel_i  in  8  master n byte selects in [4n+3:4n].
REQ-015 m_dat_i  in  64  master n write data in [32n+31:32n].
REQ-016 m_dat_o  out  32  read data, broadcast to both masters.
REQ-017 m_ack_o  out  2  per-master acknowledge.
REQ-018 m_err_o  out  2  per-master error.
REQ-019 s_cyc_o, s_we_o  out  1 each  granted master's cyc/we, gated by grant valid.
REQ-020 s_stb_o  out  3  one-hot per-slave strobe from decode.
REQ-021 s_adr_o / s_sel_o / s_dat_o  out  32/4/32  granted master's address/selects/write data.
REQ-022 s_dat_i  in  96  slave k read data in [32k+31:32k].
REQ-023 s_ack_i / s_err_i  in  3 each  per-slave acknowledge / error.

Function
REQ-024 FSM states IDLE, OWNED, FAULT; IDLE after reset.
REQ-025 IDLE: if any m_cyc_i bit set, grant registered next edge and state -> OWNED; grant visible on outputs from that edge (1-cycle arbitration latency).
REQ-026 Arbitration round-robin: both requesting -> grant the master not granted last; single requester always wins; after reset master 0 has priority.
REQ-027 OWNED: grant held while granted master keeps m_cyc_i high; other master's requests ignored (no preemption); on granted m_cyc_i low -> IDLE next edge, s_cyc_o low same cycle combinationally.
REQ-028 Decode: slave k hit iff BASEk <= adr < BASEk+SIZEk (33-bit compare, no wrap); at most one hit; s_stb_o[k] = granted stb AND hit k AND state OWNED.
REQ-029 Granted stb high with no hit -> state FAULT next edge; FAULT drives m_err_o[grant] high exactly one cycle, then -> OWNED.
REQ-030 m_ack_o[grant] = s_ack_i[hit]; m_err_o[grant] = s_err_i[hit] OR FAULT OR timeout; non-granted master's ack/err always 0.
REQ-031 m_dat_o = s_dat_i of decoded slave, 0 when no hit.
REQ-032 Timeout counter (8 bit): cleared when stb low or ack/err seen; increments each cycle granted stb high with hit and no ack/err; reaching TIMEOUT asserts m_err_o[grant] one cycle, s_stb_o forced 0 that cycle, counter cleared.
REQ-033 Simultaneous s_ack_i and s_err_i from hit slave: err wins, ack suppressed.
REQ-034 Acks from non-decoded slaves ignored.
REQ-035 Master dropping m_cyc_i mid-transfer: outputs released that cycle, counter cleared, late slave ack not forwarded.

Reset
REQ-036 On rst_ni low, immediately: state IDLE, no grant, last-grant = master 1 (so master 0 next), counter 0.
REQ-037 During reset all outputs 0: s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o, m_dat_o, s_adr_o, s_sel_o, s_dat_o.
REQ-038 Reset asserted mid-transfer aborts it; no ack/err emitted after deassertion for that transfer.

Verification
REQ-039 Master 0 read 'h2000_0010, slave 1 acks 2 cycles later with 'hDEAD_BEEF -> s_stb_o=3'b010, m_ack_o=2'b01, m_dat_o='hDEAD_BEEF same cycle.
REQ-040 Both masters raise cyc same edge after reset -> master 0 granted; after it drops cyc, master 1 granted next edge; repeat both -> master 0 again.
REQ-041 Master 1 write to 'h4000_0000 (unmapped) -> s_stb_o=0, one-cycle m_err_o=2'b10, master 0 sees nothing.
REQ-042 Master 0 strobe to 'h3000_0000, slave 2 never acks, TIMEOUT=16 -> m_err_o[0] on 17th cycle of strobe, s_stb_o 0 that cycle.
REQ-043 Slave 0 asserts ack and err together -> m_err_o[0]=1, m_ack_o[0]=0.
REQ-044 rst_ni pulled low during pending memory read -> all outputs 0 immediately; late slave ack after release produces no m_ack_o.
